uart_cmd_parser: RTL and testbench



---
 rtl/uart_cmd_parser_if.sv | 48 ++++
 rtl/uart_cmd_parser.sv | 178 +++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_parser_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_parser_if
//  Description : Bundles the UART byte stream coming into the command parser
//                and the decoded command handshake going out of it.
//                master : parser side (consumes bytes, presents commands)
//                slave  : environment side (UART receiver + SD control)
//  Signals     : rx_done_tick, rx_data       byte strobe and data
//                cmd_valid, cmd_ready        command handshake
//                cmd_op, cmd_addr            decoded command
//                cmd_err, cmd_overrun        one-cycle status pulses
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_cmd_parser_if #(
    parameter int ADDR_DIGITS = 8
);
    logic                       rx_done_tick;
    logic [7:0]                 rx_data;
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic [1:0]                 cmd_op;
    logic [4*ADDR_DIGITS-1:0]   cmd_addr;
    logic                       cmd_err;
    logic                       cmd_overrun;

    modport master (
        input  rx_done_tick,
        input  rx_data,
        input  cmd_ready,
        output cmd_valid,
        output cmd_op,
        output cmd_addr,
        output cmd_err,
        output cmd_overrun
    );

    modport slave (
        output rx_done_tick,
        output rx_data,
        output cmd_ready,
        input  cmd_valid,
        input  cmd_op,
        input  cmd_addr,
        input  cmd_err,
        input  cmd_overrun
    );
endinterface
`default_nettype wire

// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_parser
//  Description : Assembles ASCII command lines ("R/W" + ADDR_DIGITS hex digits
//                + CR/LF, or "S" + CR/LF) from a UART byte stream and presents
//                each decoded command on a valid/ready handshake. Malformed
//                lines pulse cmd_err and are discarded up to the next CR/LF.
//  Ports       : clk  - system clock
//                rst  - asynchronous active-high reset
//                bus  - uart_cmd_parser_if.master (byte in, command out)
//  Parameters  : ADDR_DIGITS - hex digits per address (1..8)
//  Options     : UART_CMD_LOWERCASE_EN - when defined, lowercase opcodes and
//                hex digits are accepted as their uppercase equivalents
//  Revision    : 1.0  initial release
// ============================================================================
module uart_cmd_parser #(
    parameter int ADDR_DIGITS = 8
) (
    input  wire logic           clk,
    input  wire logic           rst,
    uart_cmd_parser_if.master   bus
);
    localparam int ADDR_W = 4 * ADDR_DIGITS;
    localparam int CNT_W  = $clog2(ADDR_DIGITS + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_EOL     = 3'd2,
        ST_HOLD    = 3'd3,
        ST_DISCARD = 3'd4
    } state_t;

    state_t                 state_q;
    logic [1:0]             op_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [ADDR_W-1:0]      addr_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   valid_q;
    logic                   err_q;
    logic                   overrun_q;

    // Byte classification
    logic                   w_is_eol;
    logic                   w_is_hex;
    logic [3:0]             w_nibble;
    logic [1:0]             w_op;       // 00 means "not an opcode"

    always_comb begin
        w_is_eol = (bus.rx_data == 8'h0D) || (bus.rx_data == 8'h0A);
        w_is_hex = 1'b0;
        w_nibble = bus.rx_data[3:0];
        if (bus.rx_data >= 8'h30 && bus.rx_data <= 8'h39) begin
            w_is_hex = 1'b1;
        end else if (bus.rx_data >= 8'h41 && bus.rx_data <= 8'h46) begin
            // 'A'..'F' have low nibble 1..6, so +9 gives 10..15
            w_is_hex = 1'b1;
            w_nibble = bus.rx_data[3:0] + 4'd9;
        end
`ifdef UART_CMD_LOWERCASE_EN
        else if (bus.rx_data >= 8'h61 && bus.rx_data <= 8'h66) begin
            w_is_hex = 1'b1;
            w_nibble = bus.rx_data[3:0] + 4'd9;
        end
`endif

        case (bus.rx_data)
            8'h52:   w_op = 2'b01;   // 'R'
            8'h57:   w_op = 2'b10;   // 'W'
            8'h53:   w_op = 2'b11;   // 'S'
`ifdef UART_CMD_LOWERCASE_EN
            8'h72:   w_op = 2'b01;   // 'r'
            8'h77:   w_op = 2'b10;   // 'w'
            8'h73:   w_op = 2'b11;   // 's'
`endif
            default: w_op = 2'b00;
        endcase
    end

    // A single-digit address has no upper bits to keep when shifting.
    generate
        if (ADDR_DIGITS > 1) begin : g_shift_multi
            assign addr_d = {addr_q[ADDR_W-5:0], w_nibble};
        end else begin : g_shift_single
            assign addr_d = w_nibble;
        end
    endgenerate

    // Counter is only advanced in ADDR, where it is below ADDR_DIGITS.
    assign cnt_d = cnt_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= 2'b00;
            addr_q    <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            err_q     <= 1'b0;
            overrun_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.rx_done_tick && !w_is_eol) begin
                        if (w_op != 2'b00) begin
                            op_q    <= w_op;
                            addr_q  <= '0;
                            cnt_q   <= '0;
                            state_q <= (w_op == 2'b11) ? ST_EOL : ST_ADDR;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= ST_DISCARD;
                        end
                    end
                end
                ST_ADDR: begin
                    if (bus.rx_done_tick) begin
                        if (w_is_hex) begin
                            addr_q <= addr_d;
                            cnt_q  <= cnt_d;
                            if (cnt_d == CNT_W'(ADDR_DIGITS)) begin
                                state_q <= ST_EOL;
                            end
                        end else if (w_is_eol) begin
                            // Short address: the line is already over.
                            err_q   <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= ST_DISCARD;
                        end
                    end
                end
                ST_EOL: begin
                    if (bus.rx_done_tick) begin
                        if (w_is_eol) begin
                            valid_q <= 1'b1;
                            state_q <= ST_HOLD;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= ST_DISCARD;
                        end
                    end
                end
                ST_HOLD: begin
                    // Any byte here is dropped, even alongside the handshake.
                    if (bus.rx_done_tick) begin
                        overrun_q <= 1'b1;
                    end
                    if (bus.cmd_ready) begin
                        valid_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_DISCARD: begin
                    if (bus.rx_done_tick && w_is_eol) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_valid   = valid_q;
    assign bus.cmd_op      = op_q;
    assign bus.cmd_addr    = addr_q;
    assign bus.cmd_err     = err_q;
    assign bus.cmd_overrun = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_cmd_parser
//  Description : Directed self-checking bench for uart_cmd_parser with
//                ADDR_DIGITS = 8. Honours UART_CMD_LOWERCASE_EN when defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_cmd_parser;
    localparam int AD = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;
    int   err_seen;
    int   ovr_seen;
    int   hs_seen;
    int   e0;
    int   h0;

    uart_cmd_parser_if #(.ADDR_DIGITS(AD)) bus ();

    uart_cmd_parser #(.ADDR_DIGITS(AD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse / handshake tallies, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.cmd_err)                     err_seen = err_seen + 1;
        if (bus.cmd_overrun)                 ovr_seen = ovr_seen + 1;
        if (bus.cmd_valid && bus.cmd_ready)  hs_seen  = hs_seen + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_fails = n_fails + 1;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Strobes one byte; returns 1ns after the edge that consumed it, so the
    // registered response to that byte is visible. Consecutive calls give
    // back-to-back strobes.
    task automatic send_byte(input logic [7:0] b);
        bus.rx_done_tick = 1'b1;
        bus.rx_data      = b;
        @(posedge clk);
        #1;
        bus.rx_done_tick = 1'b0;
        bus.rx_data      = 8'h00;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic accept();
        bus.cmd_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_ready = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_fails = 0;
        err_seen = 0; ovr_seen = 0; hs_seen = 0;
        rst = 1'b1;
        bus.rx_done_tick = 1'b0;
        bus.rx_data      = 8'h00;
        bus.cmd_ready    = 1'b0;
        idle_cycles(3);
        check_eq("rst_valid", {31'd0, bus.cmd_valid}, 32'd0);
        check_eq("rst_op",    {30'd0, bus.cmd_op},    32'd0);
        check_eq("rst_addr",  bus.cmd_addr,           32'd0);
        check_eq("rst_pulses", {30'd0, bus.cmd_err, bus.cmd_overrun}, 32'd0);
        rst = 1'b0;
        idle_cycles(2);

        // Read command held while consumer stalls
        send_str("R0000ABCD");
        check_eq("r_no_early_valid", {31'd0, bus.cmd_valid}, 32'd0);
        send_byte(8'h0D);
        check_eq("r_valid", {31'd0, bus.cmd_valid}, 32'd1);
        check_eq("r_op",    {30'd0, bus.cmd_op},    32'd1);
        check_eq("r_addr",  bus.cmd_addr,           32'h0000ABCD);
        for (int i = 0; i < 5; i++) begin
            idle_cycles(1);
            check_eq("r_hold_valid", {31'd0, bus.cmd_valid}, 32'd1);
            check_eq("r_hold_addr",  bus.cmd_addr,           32'h0000ABCD);
        end
        accept();
        check_eq("r_valid_drop", {31'd0, bus.cmd_valid}, 32'd0);

        // Status command with leading CRLF, consumer always ready
        h0 = hs_seen;
        bus.cmd_ready = 1'b1;
        send_str("\r\nS\r");
        check_eq("s_valid", {31'd0, bus.cmd_valid}, 32'd1);
        check_eq("s_op",    {30'd0, bus.cmd_op},    32'd3);
        check_eq("s_addr",  bus.cmd_addr,           32'd0);
        idle_cycles(2);
        check_eq("s_valid_drop", {31'd0, bus.cmd_valid}, 32'd0);
        check_eq("s_one_hs", hs_seen - h0, 32'd1);
        bus.cmd_ready = 1'b0;

        // Bad hex digit, then a good write
        e0 = err_seen;
        send_str("R12G");
        check_eq("g_err_pulse", {31'd0, bus.cmd_err}, 32'd1);
        send_str("4567\r");
        check_eq("g_one_err",  err_seen - e0, 32'd1);
        check_eq("g_no_valid", {31'd0, bus.cmd_valid}, 32'd0);
        send_str("W00000001\n");
        check_eq("w_valid", {31'd0, bus.cmd_valid}, 32'd1);
        check_eq("w_op",    {30'd0, bus.cmd_op},    32'd2);
        check_eq("w_addr",  bus.cmd_addr,           32'h00000001);
        accept();

        // Short address, then long address
        e0 = err_seen;
        send_str("W1234");
        check_eq("short_no_err_yet", {31'd0, bus.cmd_err}, 32'd0);
        send_byte(8'h0D);
        check_eq("short_err_on_cr", {31'd0, bus.cmd_err}, 32'd1);
        send_str("R00000000");
        check_eq("long_no_err_yet", {31'd0, bus.cmd_err}, 32'd0);
        send_byte("1");
        check_eq("long_err_9th", {31'd0, bus.cmd_err}, 32'd1);
        send_byte(8'h0D);
        idle_cycles(2);
        check_eq("bad_lines_errs",  err_seen - e0, 32'd2);
        check_eq("bad_lines_valid", {31'd0, bus.cmd_valid}, 32'd0);

        // Overrun while held, then overrun coincident with ready
        e0 = err_seen;
        send_str("R89ABCDEF\r");
        check_eq("ov_valid", {31'd0, bus.cmd_valid}, 32'd1);
        send_byte("X");
        check_eq("ov_pulse",  {31'd0, bus.cmd_overrun}, 32'd1);
        check_eq("ov_valid2", {31'd0, bus.cmd_valid},   32'd1);
        check_eq("ov_addr",   bus.cmd_addr,             32'h89ABCDEF);
        idle_cycles(1);
        check_eq("ov_pulse_end", {31'd0, bus.cmd_overrun}, 32'd0);
        bus.cmd_ready = 1'b1;
        send_byte("X");
        bus.cmd_ready = 1'b0;
        check_eq("ov2_pulse", {31'd0, bus.cmd_overrun}, 32'd1);
        check_eq("ov2_valid", {31'd0, bus.cmd_valid},   32'd0);
        check_eq("ov2_addr",  bus.cmd_addr,             32'h89ABCDEF);
        idle_cycles(2);
        check_eq("ov_x_not_parsed", err_seen - e0, 32'd0);
        send_str("S\r");
        check_eq("ov_idle_after", {30'd0, bus.cmd_op}, 32'd3);
        accept();
        check_eq("ov_total", ovr_seen, 32'd2);

        // Lowercase command
        e0 = err_seen;
        send_byte("r");
`ifdef UART_CMD_LOWERCASE_EN
        check_eq("lc_no_err", {31'd0, bus.cmd_err}, 32'd0);
        send_str("0000abcd\r");
        check_eq("lc_valid", {31'd0, bus.cmd_valid}, 32'd1);
        check_eq("lc_op",    {30'd0, bus.cmd_op},    32'd1);
        check_eq("lc_addr",  bus.cmd_addr,           32'h0000ABCD);
        accept();
`else
        check_eq("lc_err", {31'd0, bus.cmd_err}, 32'd1);
        send_str("0000abcd\r");
        idle_cycles(1);
        check_eq("lc_no_valid", {31'd0, bus.cmd_valid}, 32'd0);
        check_eq("lc_one_err",  err_seen - e0, 32'd1);
`endif

        // Reset mid-address
        e0 = err_seen;
        send_str("W12");
        #2;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_valid", {31'd0, bus.cmd_valid}, 32'd0);
        check_eq("mid_rst_op",    {30'd0, bus.cmd_op},    32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_str("R00000010\r");
        check_eq("post_rst_valid", {31'd0, bus.cmd_valid}, 32'd1);
        check_eq("post_rst_op",    {30'd0, bus.cmd_op},    32'd1);
        check_eq("post_rst_addr",  bus.cmd_addr,           32'h00000010);
        check_eq("post_rst_no_err", err_seen - e0, 32'd0);
        accept();
        idle_cycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end
endmodule
`default_nettype wire
